// File: rtl/delay_pkg.sv
// Shared types and defaults for the multi-channel delay timer.
// Imported by the channel and top-level modules.
package delay_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 32;

endpackage

// File: rtl/delay_channel.sv
// One delay channel: arm, count down, strobe done, optional reload.
// Abort wins over every other event in the same cycle.
module delay_channel
  import delay_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             periodic,
  input  logic [CNT_W-1:0] delay_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] dly, dly_n;
  logic             per, per_n;
  logic             done_n;

  // State, counter, latched delay/mode and done strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dly   <= '0;
      per   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dly   <= dly_n;
      per   <= per_n;
      done  <= done_n;
    end
  end

  // Next-state: arm, decrement, terminal count, reload, abort
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dly_n   = dly;
    per_n   = per;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          dly_n   = (delay_in == '0) ? CNT_W'(1) : delay_in;
          per_n   = periodic;
          cnt_n   = dly_n;
          state_n = COUNT;
        end
      end
      COUNT: begin
        if (abort) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(1)) begin
          done_n = 1'b1;
          if (per) begin
            cnt_n = dly;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign busy      = (state == COUNT);
  assign remaining = cnt;

endmodule

// File: rtl/multi_delay_timer.sv
// NUM_CH independent delay channels with packed vector ports.
// Each channel slice maps straight onto one delay_channel.
module multi_delay_timer
  import delay_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       abort,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH*CNT_W-1:0] delay_in,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH*CNT_W-1:0] remaining
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    delay_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[i]),
      .abort    (abort[i]),
      .periodic (periodic[i]),
      .delay_in (delay_in[i*CNT_W +: CNT_W]),
      .busy     (busy[i]),
      .done     (done[i]),
      .remaining(remaining[i*CNT_W +: CNT_W])
    );
  end

endmodule
